// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo sample FIFO feeding the I2S shifter.
package audio_pkg;

    localparam int unsigned AUDIO_DW = 15;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } audio_state_e;

    localparam logic [7:0] UNDERRUN_CNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == UNDERRUN_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read with a clear for refill.
module audio_fifo_ram #(
    parameter int unsigned Width = 30,
    parameter int unsigned AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_clr_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [Width-1:0] rd_data_o
);

    logic [Width-1:0] mem_q [2**AW];
    logic [Width-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr_i) begin
            rd_data_d = '0;
        end else if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // The read register is the output register seen by the shifter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO: accepts L/R pairs from the mixer and releases one pair per LR frame.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DW                 = AUDIO_DW,
    parameter int unsigned AW                 = 3,
    parameter bit          REFILL_ON_UNDERRUN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_ldata,
    input  logic [DW-1:0] in_rdata,
    input  logic          lrck,
    input  logic          clr_flags,
    output logic [DW-1:0] ldata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          underrun,
    output logic          overrun,
    output logic [7:0]    underrun_cnt
);

    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FullLevel = LW'(2 ** AW);
    localparam logic [AW:0] HalfLevel = LW'(2 ** (AW - 1));

    audio_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          lrck_dly_q, lrck_dly_d;
    logic          armed_q, armed_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    ucnt_q, ucnt_d;

    logic frame_edge, push, pop, underrun_ev, overrun_ev, rd_clr;

    assign in_ready = (level_q != FullLevel);
    assign push     = in_valid & in_ready;
    // After reset, lrck must be seen low before a rising edge counts as a frame.
    assign frame_edge = lrck & ~lrck_dly_q & armed_q;
    assign overrun_ev = in_valid & ~in_ready;

    always_comb begin
        pop         = 1'b0;
        underrun_ev = 1'b0;
        state_d     = state_q;
        case (state_q)
            ST_FILL: begin
                if (frame_edge && level_q >= HalfLevel) begin
                    pop     = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_edge) begin
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun_ev = 1'b1;
                        if (REFILL_ON_UNDERRUN) begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign rd_clr = underrun_ev & REFILL_ON_UNDERRUN;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        lrck_dly_d = lrck;
        armed_d    = armed_q | ~lrck;

        // A new event in the same cycle as clr_flags takes priority.
        underrun_d = underrun_ev ? 1'b1 : (clr_flags ? 1'b0 : underrun_q);
        overrun_d  = overrun_ev ? 1'b1 : (clr_flags ? 1'b0 : overrun_q);
        ucnt_d     = ucnt_q;
        if (clr_flags) begin
            ucnt_d = underrun_ev ? 8'd1 : 8'd0;
        end else if (underrun_ev) begin
            ucnt_d = sat_inc8(ucnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            lrck_dly_q <= 1'b0;
            armed_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            lrck_dly_q <= lrck_dly_d;
            armed_q    <= armed_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    logic [2*DW-1:0] rd_pair;

    audio_fifo_ram #(
        .Width (2 * DW),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({in_ldata, in_rdata}),
        .rd_en_i   (pop),
        .rd_clr_i  (rd_clr),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_pair)
    );

    assign ldata        = rd_pair[2*DW-1:DW];
    assign rdata        = rd_pair[DW-1:0];
    assign level        = level_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Stereo sample buffer directly upstream of the I2S output shifter.
- Accepts 15-bit L/R sample pairs from the Paula/CD mixing path with a valid/ready handshake.
- Releases exactly one pair per audio frame, on the rising edge of the shifter's LR clock.
- Holds rdata/ldata stable for the whole frame, decoupling bursty producers from the fixed-rate serialiser.

Parameters:
- DW, 15, sample width per channel (two's complement).
- AW, 3, FIFO address width; depth = 2**AW stereo pairs.
- REFILL_ON_UNDERRUN, 1, 1 = return to FILL after an underrun; 0 = stay in RUN and hold the last sample.

Ports:
- clk  in  1  system clock (32 MHz)
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a sample pair
- in_ready  out  1  FIFO can accept a pair this cycle
- in_ldata  in  DW  left sample
- in_rdata  in  DW  right sample
- lrck  in  1  frame clock from the shifter (same clk domain)
- clr_flags  in  1  clears the sticky flags and the underrun counter
- ldata  out  DW  left sample to the shifter
- rdata  out  DW  right sample to the shifter
- level  out  AW+1  current fill count, 0..2**AW
- underrun  out  1  sticky: a pop was attempted while empty
- overrun  out  1  sticky: in_valid was asserted while in_ready was low
- underrun_cnt  out  8  saturating count of underrun frames

Behaviour:
- Reset (async, active-high) clears:
  - pointers and level to 0; ldata and rdata to 0
  - underrun, overrun and underrun_cnt to 0
  - state to FILL; lrck_d (lrck delayed one cycle) to 0
- in_ready = (level != 2**AW), taken from registered level.
  - When full, in_ready stays 0 even if a pop occurs in the same cycle; no combinational ready path.
- Push: in_valid & in_ready.
  - Writes {in_ldata, in_rdata} at the write pointer; the pointer wraps modulo 2**AW.
- frame_edge = lrck & ~lrck_d (single-cycle pulse).
- State FILL:
  - ldata and rdata are driven to 0; no pops; no underrun counting.
  - Moves to RUN on a frame_edge where level >= 2**(AW-1). That same edge performs the first pop.
- State RUN, on each frame_edge:
  - If level != 0: pop. ldata/rdata take the head pair on the next clk (1-cycle latency from frame_edge); the read pointer wraps modulo 2**AW.
  - If level == 0: underrun. ldata/rdata hold their previous values; underrun is set; underrun_cnt increments and saturates at 255.
    - REFILL_ON_UNDERRUN=1: next state is FILL, and outputs go to 0 on the next cycle.
    - REFILL_ON_UNDERRUN=0: stay in RUN.
- Simultaneous push and pop: level is unchanged.
- Push while empty coinciding with a frame_edge: counts as an underrun. There is no bypass; the pushed pair stays in the FIFO.
- Overrun: in_valid & ~in_ready sets overrun. The sample is not written; the producer must hold it.
- level updates on the clk after a push or pop.
- clr_flags clears underrun, overrun and underrun_cnt.
  - If clr_flags coincides with a new event, the event wins (flag set, count = 1).
- Reset mid-frame: FIFO contents are discarded; the next frame_edge is taken only after lrck has been seen low then high.
- Outputs are registered; nothing is combinational from the inputs except in_ready's dependence on registered level.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DW = 15
  - state encoding ST_FILL = 1'b0, ST_RUN = 1'b1
  - UNDERRUN_CNT_MAX = 8'd255
- One natural sub-module: audio_fifo_ram.
  - Simple dual-port, 2**AW x 2*DW.
  - Synchronous write, registered read.
  - Read data aligns with the 1-cycle output latency.

Test Plan:
- Fill and start (AW=3): push 4 pairs (L=0x0001..0x0004, R=0x7001..0x7004), then toggle lrck. On the first frame_edge the state goes FILL->RUN; one clk later ldata=0x0001, rdata=0x7001; level=3.
- Full back-pressure: push 8 pairs with lrck held low. level=8, in_ready=0. Hold in_valid for 3 more cycles: overrun=1 and no write occurs. After the next pop, in_ready=1 and the held pair is accepted.
- Underrun with REFILL_ON_UNDERRUN=1: in RUN with level=1, apply 2 frame_edges without pushing. The first pops; the second sets underrun=1 and underrun_cnt=1, the state goes to FILL, and outputs become 0 one clk later.
- Underrun with REFILL_ON_UNDERRUN=0: empty in RUN, last output L=0x1234; apply 300 frame_edges. ldata stays 0x1234 and underrun_cnt saturates at 255. clr_flags returns the count to 0.
- Simultaneous push and pop at level=5: level stays 5; output equals the old head; the new pair is at the tail, verified by draining.
- Async reset asserted mid-RUN with level=6, lrck high: all outputs are 0 immediately. After release, lrck held high produces no pop; a pop requires lrck to go low then high and then the FILL threshold to be reached.
